// File: rtl/la_pkg.sv
// la_pkg: shared sample types for the logic-analyser front end
package la_pkg;
  typedef struct packed {
    logic h;
    logic l;
  } smpl2_t;
  localparam int SMPL_W_DEFAULT = 8;
endpackage

// File: rtl/la_sync_bit.sv
// la_sync_bit: multi-flop metastability synchroniser for one asynchronous bit
module la_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/channel_sampler_multi.sv
// channel_sampler_multi: per-channel H/L synchronisation, sample history and word packing
module channel_sampler_multi
  import la_pkg::*;
#(
  parameter int NUM_CH         = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int SMPLS_PER_WORD = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           smpl_en,
  input  logic                           capture_en,
  input  logic                           packed_mode,
  input  logic [NUM_CH-1:0]              CH_H,
  input  logic [NUM_CH-1:0]              CH_L,
  output logic [NUM_CH-1:0]              CH_Htrig,
  output logic [NUM_CH-1:0]              CH_Ltrig,
  output logic [NUM_CH*2*SMPLS_PER_WORD-1:0] smpl,
  output logic                           smpl_vld
);
  localparam int W = 2 * SMPLS_PER_WORD;
  localparam int SLOT_W = SMPLS_PER_WORD > 1 ? $clog2(SMPLS_PER_WORD) : 1;
  logic [NUM_CH-1:0] h_s, l_s;
  logic [NUM_CH*W-1:0] hist_q, hist_d, smpl_q;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_b;
  logic pm_q, pend_q, pend_d, vld_q, mode_chg, wrap;
  // History is kept directly in word format: newest entry in the MSBs, oldest in bits [1:0]
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    smpl2_t new_s;
    la_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h (.clk(clk), .rst(rst), .d_i(CH_H[c]), .q_o(h_s[c]));
    la_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (.clk(clk), .rst(rst), .d_i(CH_L[c]), .q_o(l_s[c]));
    assign new_s = '{h: h_s[c], l: l_s[c]};
    if (SMPLS_PER_WORD == 1) begin : g_one
      assign hist_d[c*W +: W] = new_s;
    end else begin : g_shift
      assign hist_d[c*W +: W] = {new_s, hist_q[c*W+2 +: W-2]};
    end
    assign CH_Htrig[c] = hist_q[c*W+1];
    assign CH_Ltrig[c] = hist_q[c*W];
  end
  always_comb begin
    mode_chg = capture_en & (packed_mode != pm_q);
    slot_b   = mode_chg ? '0 : slot_q;
    wrap     = slot_b == SLOT_W'(SMPLS_PER_WORD - 1);
    slot_d   = !capture_en ? '0 : (smpl_en & packed_mode) ? (wrap ? '0 : slot_b + 1'b1) : slot_b;
    pend_d   = capture_en & smpl_en & (!packed_mode | wrap);
  end
  // Words are taken from the history one clk after the strobe that completed them
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      slot_q <= '0;
      pm_q   <= 1'b0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      smpl_q <= '0;
    end else begin
      if (smpl_en) hist_q <= hist_d;
      slot_q <= slot_d;
      pm_q   <= packed_mode;
      pend_q <= pend_d;
      vld_q  <= pend_q;
      if (pend_q) smpl_q <= hist_q;
    end
  end
  assign smpl     = smpl_q;
  assign smpl_vld = vld_q;
endmodule

// File: tb/tb_channel_sampler_multi.sv
// tb_channel_sampler_multi: directed checks of sync latency, history, sliding/packed words and reset
module tb_channel_sampler_multi;
  logic clk = 1'b0, rst, smpl_en, capture_en, packed_mode;
  logic [1:0] CH_H, CH_L, CH_Htrig, CH_Ltrig;
  logic [15:0] smpl;
  logic smpl_vld;
  int n_cmp = 0, n_err = 0, cnt;
  logic [3:0] h0 = 4'b0011, l0 = 4'b1001;
  logic [15:0] slide_exp [4] = '{16'h40EA, 16'h50BA, 16'h542E, 16'h554B};

  channel_sampler_multi #(.NUM_CH(2), .SYNC_STAGES(2), .SMPLS_PER_WORD(4)) dut (
    .clk(clk), .rst(rst), .smpl_en(smpl_en), .capture_en(capture_en), .packed_mode(packed_mode),
    .CH_H(CH_H), .CH_L(CH_L), .CH_Htrig(CH_Htrig), .CH_Ltrig(CH_Ltrig), .smpl(smpl), .smpl_vld(smpl_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    smpl_en = 1'b1;
    tick();
    smpl_en = 1'b0;
  endtask

  task automatic samples(input int n, output int c);
    c = 0;
    repeat (n) begin
      smpl_en = 1'b1;
      tick();
      c += int'(smpl_vld);
      smpl_en = 1'b0;
      tick();
      c += int'(smpl_vld);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; smpl_en = 1'b0; capture_en = 1'b1; packed_mode = 1'b0; CH_H = '0; CH_L = '0;
    for (int i = 0; i < 3; i++) begin
      CH_H = ~CH_H; CH_L = 2'(i); smpl_en = ~smpl_en; packed_mode = ~packed_mode;
      tick();
    end
    chk("rst_htrig", 32'(CH_Htrig), 0);
    chk("rst_ltrig", 32'(CH_Ltrig), 0);
    chk("rst_smpl", 32'(smpl), 0);
    chk("rst_vld", 32'(smpl_vld), 0);
    rst = 1'b0; smpl_en = 1'b0; capture_en = 1'b0; packed_mode = 1'b0; CH_H = 2'b11; CH_L = 2'b00;
    repeat (4) tick();
    chk("idle_htrig", 32'(CH_Htrig), 0);
    chk("idle_smpl", 32'(smpl), 0);
    CH_H = 2'b00;
    repeat (3) tick();
    CH_H = 2'b01;
    tick(); tick();
    sample();
    chk("sync_trig_1", 32'(CH_Htrig), 0);
    sample(); sample();
    chk("sync_trig_3", 32'(CH_Htrig), 0);
    sample();
    chk("sync_trig_4", 32'(CH_Htrig), 32'h1);
    chk("sync_ltrig_4", 32'(CH_Ltrig), 0);
    chk("sync_nocap_vld", 32'(smpl_vld), 0);
    capture_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      CH_H = {1'b0, h0[i]}; CH_L = {1'b1, l0[i]};
      tick(); tick();
      sample();
      if (i == 0) chk("slide_lat", 32'(smpl_vld), 0);
      tick();
      chk("slide_vld", 32'(smpl_vld), 1);
      chk("slide_word", 32'(smpl), 32'(slide_exp[i]));
    end
    chk("slide_htrig", 32'(CH_Htrig), 32'h1);
    chk("slide_ltrig", 32'(CH_Ltrig), 32'h3);
    packed_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      CH_H = {1'b1, h0[i]}; CH_L = {1'b0, l0[i]};
      tick(); tick();
      sample();
      tick();
      chk("pack_vld", 32'(smpl_vld), (i == 3) ? 1 : 0);
      if (i == 2) chk("pack_hold", 32'(smpl), 32'h554B);
    end
    chk("pack_word", 32'(smpl), 32'hAA4B);
    samples(8, cnt);
    chk("pack_8_pulses", 32'(cnt), 2);
    samples(2, cnt);
    chk("cap_partial", 32'(cnt), 0);
    capture_en = 1'b0;
    tick();
    capture_en = 1'b1;
    tick();
    samples(3, cnt);
    chk("cap_restart_3", 32'(cnt), 0);
    samples(1, cnt);
    chk("cap_restart_4", 32'(cnt), 1);
    packed_mode = 1'b0;
    tick();
    smpl_en = 1'b1;
    tick();
    chk("b2b_e1", 32'(smpl_vld), 0);
    tick();
    chk("b2b_e2", 32'(smpl_vld), 1);
    tick();
    chk("b2b_e3", 32'(smpl_vld), 1);
    smpl_en = 1'b0;
    tick();
    chk("b2b_e4", 32'(smpl_vld), 1);
    tick();
    chk("b2b_e5", 32'(smpl_vld), 0);
    packed_mode = 1'b1; CH_H = 2'b10; CH_L = 2'b01;
    tick(); tick();
    samples(3, cnt);
    chk("midrst_pre", 32'(cnt), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_smpl", 32'(smpl), 0);
    chk("midrst_vld", 32'(smpl_vld), 0);
    chk("midrst_htrig", 32'(CH_Htrig), 0);
    chk("midrst_ltrig", 32'(CH_Ltrig), 0);
    tick(); tick();
    samples(3, cnt);
    chk("postrst_3", 32'(cnt), 0);
    samples(1, cnt);
    chk("postrst_4", 32'(cnt), 1);
    chk("postrst_word", 32'(smpl), 32'hAA55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/channel_sampler_multi.md
Name: channel_sampler_multi

Overview:
- Multi-channel successor of the single-channel sampler. Runs entirely on the system clock `clk`; sample instants come from a one-cycle `smpl_en` strobe produced by the decimator, not from a separate sample clock.
- Synchronises NUM_CH pairs of comparator outputs (CH_H/CH_L) and keeps a per-channel sample history.
- Presents delayed per-channel bits to the trigger logic, and assembles history words (sliding-window or packed) with a valid strobe for the per-channel RAM queues.

Parameters:
- NUM_CH, 5, number of analog channels (each has an H and an L comparator).
- SYNC_STAGES, 2, metastability flops per input bit, clocked every clk; legal range 2..4.
- SMPLS_PER_WORD, 4, 2-bit samples packed per output word; word width W = 2*SMPLS_PER_WORD.

Ports:
- clk  in  1  system clock, only clock of the block.
- rst  in  1  synchronous, active-high reset.
- smpl_en  in  1  one-cycle sample strobe from the decimator.
- capture_en  in  1  high enables word output; low clears the packed-word slot counter.
- packed_mode  in  1  0 = sliding-window word every sample; 1 = word after every SMPLS_PER_WORD new samples.
- CH_H  in  NUM_CH  unsynchronised VIH comparator outputs.
- CH_L  in  NUM_CH  unsynchronised VIL comparator outputs.
- CH_Htrig  out  NUM_CH  oldest H history bit per channel, to trigger logic.
- CH_Ltrig  out  NUM_CH  oldest L history bit per channel, to trigger logic.
- smpl  out  NUM_CH*W  per-channel sample words; channel c occupies bits [c*W +: W].
- smpl_vld  out  1  one-cycle strobe: smpl holds a new word.

Behaviour:
- Interface fixed: single clock `clk`; reset `rst` is synchronous and active-high. Every flop clears to 0 on a clk edge with rst=1.
- Reset clears the sync chains, history, slot counter, CH_Htrig, CH_Ltrig, smpl and smpl_vld. Reset mid-word discards the partial word; no smpl_vld is emitted for it.
- Synchroniser: each CH_H/CH_L bit passes SYNC_STAGES flops that shift on every clk, independent of smpl_en.
- History: per channel, SMPLS_PER_WORD entries of {H,L}. On an edge with smpl_en=1, entry0 ← synchroniser output and entry k ← entry k-1. Without smpl_en the history holds.
- Trigger outputs: CH_Htrig/CH_Ltrig = entry SMPLS_PER_WORD-1 (oldest), combinationally from the history flops. They change only on smpl_en edges.
- Word format: {H0,L0,H1,L1,...,H(n-1),L(n-1)}, where entry0 (newest) is in the MSBs.
- Latency: smpl and smpl_vld are registered from the history one clk after the smpl_en edge that updated it.
- packed_mode=0, capture_en=1: every smpl_en causes smpl update and smpl_vld=1 on the following cycle.
- packed_mode=1, capture_en=1:
  - slot counter (width clog2(SMPLS_PER_WORD), or 1 bit if SMPLS_PER_WORD=1) increments on each smpl_en.
  - When it wraps from SMPLS_PER_WORD-1 to 0, smpl is updated and smpl_vld=1 on the following cycle. All other cycles hold smpl with smpl_vld=0.
- capture_en=0: history and trigger outputs still update; smpl holds, smpl_vld=0, slot counter forced to 0. The first word after capture_en rises requires a full SMPLS_PER_WORD samples in packed mode.
- smpl_en on consecutive cycles is legal; each strobe is one sample. smpl_vld may then be high on consecutive cycles in mode 0.
- packed_mode change: takes effect at the next smpl_en. Changing it while capture_en=1 also zeroes the slot counter.
- smpl_vld is never high for more than one cycle per qualifying smpl_en. No backpressure: the consumer must accept every strobe.

Decomposition:
- Shared package la_pkg: typedef smpl2_t = struct packed {logic h; logic l;}, and constant SMPL_W_DEFAULT = 8.
- Sub-module: la_sync_bit (parametrised by SYNC_STAGES), instantiated 2*NUM_CH times via generate. History and packing stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles with inputs toggling → all outputs 0. Deassert; drive CH_H=all 1s, CH_L=0, no smpl_en → trig and smpl stay 0.
- Sync latency: SYNC_STAGES=2, NUM_CH=2. Set CH_H[0]=1, pulse smpl_en 2 cycles later → history entry0 H=1. After 3 further smpl_en, CH_Htrig[0]=1.
- Sliding mode, SMPLS_PER_WORD=4, ch0 {H,L} sequence 11,10,00,01 on 4 smpl_en → smpl_vld 4 times. Last word ch0 = 8'b01_00_10_11.
- Packed mode: same sequence → exactly one smpl_vld, one cycle after the 4th smpl_en, ch0 = 8'h4B. Eight strobes give two pulses.
- capture_en low after 2 of 4 packed samples, then high → no vld until 4 new samples. Back-to-back smpl_en in mode 0 → vld high on consecutive cycles.
- rst asserted after 3 packed samples → no vld, outputs 0. The next word needs 4 fresh samples.
